instruction_encoder: RTL and testbench

Packs decoded instruction fields (opcode, registers, functs, full 32-bit immediate) into a 32-bit RV32I instruction word. It is the inverse of the core's immediate decoding path. It sits in front of instruction memory in the test/boot-loader path so that programs can be generated in hardware. It also expands the `li` pseudo-instruction into an LUI/ADDI pair through a small state machine. Input and output use valid/ready handshakes with a registered output stage.

---
 rtl/instruction_encoder_pkg.sv | 37 +++
 rtl/instruction_encoder_packer.sv | 55 +++++
 rtl/instruction_encoder.sv | 138 +++++++++++++
 tb/tb_instruction_encoder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I opcode constants (also used by the decoder) and the types and
// helpers common to the instruction encoder files.
`ifndef RV32I_OPCODES_DEFINED
`define RV32I_OPCODES_DEFINED
`define LUI            7'b0110111
`define AUIPC          7'b0010111
`define JAL            7'b1101111
`define JALR           7'b1100111
`define BRANCH         7'b1100011
`define LOAD           7'b0000011
`define STORE          7'b0100011
`define ARITHMETIC_IMM 7'b0010011
`define ARITHMETIC     7'b0110011
`endif

package instruction_encoder_pkg;

  // IDLE accepts bundles; SECOND holds the ADDI half of a large li.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } enc_state_e;

  // ADDI x0, x0, 0 -- emitted in place of an unknown opcode.
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [2:0]  FUNCT3_ADD = 3'b000;
  localparam logic [4:0]  REG_X0     = 5'd0;

  // True when v is representable as a bits-wide two's complement value,
  // i.e. v[31:bits-1] are all copies of the same bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] upper;
    upper = 32'($signed(v) >>> (bits - 1));
    return (upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instruction_encoder_packer.sv
// Combinational packer: decoded fields plus a full 32-bit immediate become one
// RV32I word, with a flag when the immediate does not fit the format.
module instruction_packer
  import instruction_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        error_o
);

  // Select the format from the opcode; out-of-range fields are still truncated
  // into the word so downstream sees a deterministic value alongside the flag.
  always_comb begin
    word_o  = NOP_WORD;
    error_o = 1'b1;
    case (opcode_i)
      `ARITHMETIC: begin
        word_o  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        error_o = 1'b0;
      end
      `ARITHMETIC_IMM, `LOAD, `JALR: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        error_o = !fits_signed(imm_i, 12);
      end
      `STORE: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        error_o = !fits_signed(imm_i, 12);
      end
      `BRANCH: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        error_o = !fits_signed(imm_i, 13) || imm_i[0];
      end
      `LUI, `AUIPC: begin
        word_o  = {imm_i[31:12], rd_i, opcode_i};
        error_o = |imm_i[11:0];
      end
      `JAL: begin
        word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        error_o = !fits_signed(imm_i, 21) || imm_i[0];
      end
      default: begin
        word_o  = NOP_WORD;
        error_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs field bundles into words behind a registered
// valid/ready output stage and expands li into ADDI or LUI(+ADDI).
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        in_li,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        out_error
);

  enc_state_e  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] pack_word;
  logic        pack_err;
  logic        slot_free;
  logic        accept;

  logic        li_fits;
  logic        li_lo_zero;
  logic [19:0] li_hi;
  logic [31:0] li_addi_x0;
  logic [31:0] li_lui;
  logic [31:0] li_addi_rd;

  instruction_packer u_packer (
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .error_o  (pack_err)
  );

  // li candidates; hi absorbs the carry because ADDI sign-extends its 12 bits.
  always_comb begin
    li_fits    = fits_signed(in_imm, 12);
    li_lo_zero = (in_imm[11:0] == 12'h000);
    li_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
    li_addi_x0 = {in_imm[11:0], REG_X0, FUNCT3_ADD, in_rd, `ARITHMETIC_IMM};
    li_lui     = {li_hi, in_rd, `LUI};
    li_addi_rd = {in_imm[11:0], in_rd, FUNCT3_ADD, in_rd, `ARITHMETIC_IMM};
  end

  // The output register may be reloaded when empty or being drained this edge.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  // Next-state and output-register loading for the IDLE/SECOND machine.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    pend_d      = pend_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          if (in_li) begin
            out_err_d = 1'b0;
            if (li_fits) begin
              out_instr_d = li_addi_x0;
            end else begin
              out_instr_d = li_lui;
              if (!li_lo_zero) begin
                pend_d  = li_addi_rd;
                state_d = ST_SECOND;
              end
            end
          end else begin
            out_instr_d = pack_word;
            out_err_d   = pack_err;
          end
        end
      end
      ST_SECOND: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_instr_d = pend_q;
          out_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and output stage, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
    end
  end

  // Pending ADDI word; only meaningful while in SECOND, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign out_valid       = out_valid_q;
  assign out_instruction = out_instr_q;
  assign out_error       = out_err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_R      = 7'h33;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        in_li = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instruction;
  logic        out_error;

  int checks = 0;
  int failures = 0;
  bit bp_en = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic        err;
    logic [31:0] imm;
    logic [6:0]  op;
    bit          rt;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        li;
  } vec_t;
  vec_t vq[$];

  instruction_encoder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_rd           (in_rd),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_funct3       (in_funct3),
    .in_funct7       (in_funct7),
    .in_imm          (in_imm),
    .in_li           (in_li),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_error       (out_error)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit in_srange(input logic [31:0] v, input int bits);
    longint s;
    longint lim;
    s   = longint'($signed(v));
    lim = longint'(1) << (bits - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  // Immediate recovery the way a decoder would do it.
  function automatic logic [31:0] decode_imm(input logic [31:0] w, input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: return {{20{w[31]}}, w[31:20]};
      OP_STORE:                 return {{20{w[31]}}, w[31:25], w[11:7]};
      OP_BRANCH:                return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         return {w[31:12], 12'h000};
      OP_JAL:                   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:                  return 32'h0;
    endcase
  endfunction

  task automatic push(input logic [31:0] w, input logic e, input logic [31:0] imm,
                      input logic [6:0] op, input bit rt);
    exp_t t;
    t.word = w; t.err = e; t.imm = imm; t.op = op; t.rt = rt;
    expq.push_back(t);
  endtask

  // Reference model: words expected for one accepted bundle.
  task automatic model_accept(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic li);
    logic [31:0] d, s1, s2, f3w, lo, hi, w;
    logic e;
    d   = 32'(rd) << 7;
    s1  = 32'(rs1) << 15;
    s2  = 32'(rs2) << 20;
    f3w = 32'(f3) << 12;
    lo  = imm & 32'hFFF;
    if (li) begin
      if (in_srange(imm, 12)) begin
        push((lo << 20) | d | 32'(OP_IMM), 1'b0, imm, OP_IMM, 1'b1);
      end else begin
        hi = (imm + 32'd2048) & 32'hFFFF_F000;
        push(hi | d | 32'(OP_LUI), 1'b0, 32'h0, OP_LUI, 1'b0);
        if (lo != 0) push((lo << 20) | (32'(rd) << 15) | d | 32'(OP_IMM), 1'b0, 32'h0, OP_IMM, 1'b0);
      end
    end else begin
      case (op)
        OP_R: push((32'(f7) << 25) | s2 | s1 | f3w | d | 32'(op), 1'b0, 32'h0, op, 1'b0);
        OP_IMM, OP_LOAD, OP_JALR:
          push((lo << 20) | s1 | f3w | d | 32'(op), !in_srange(imm, 12), imm, op, 1'b1);
        OP_STORE:
          push((((imm >> 5) & 32'h7F) << 25) | s2 | s1 | f3w | ((imm & 32'h1F) << 7) | 32'(op),
               !in_srange(imm, 12), imm, op, 1'b1);
        OP_BRANCH: begin
          w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | f3w |
              (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
          e = !in_srange(imm, 13) || (imm % 2 != 0);
          push(w, e, imm, op, 1'b1);
        end
        OP_LUI, OP_AUIPC:
          push((imm & 32'hFFFF_F000) | d | 32'(op), lo != 0, imm, op, 1'b1);
        OP_JAL: begin
          w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
              (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'(op);
          e = !in_srange(imm, 21) || (imm % 2 != 0);
          push(w, e, imm, op, 1'b1);
        end
        default: push(32'h0000_0013, 1'b1, 32'h0, op, 1'b0);
      endcase
    end
  endtask

  // Compare process: every output handshake against the model, plus stall rules.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_word;
  logic        prev_err;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check32("stall_word_stable", out_instruction, prev_word);
        check32("stall_err_stable", 32'(out_error), 32'(prev_err));
      end
      if (out_valid && !out_ready) check32("stall_in_ready", 32'(in_ready), 32'h0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: actual=%h required=none", out_instruction);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check32("word", out_instruction, e.word);
          check32("error", 32'(out_error), 32'(e.err));
          if (e.rt && !e.err) check32("roundtrip_imm", decode_imm(out_instruction, e.op), e.imm);
        end
      end
      if (in_valid && in_ready)
        model_accept(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_li);
      prev_stall = out_valid && !out_ready;
      prev_word  = out_instruction;
      prev_err   = out_error;
    end
  end

  // Optional random backpressure.
  always @(posedge clk) begin
    #2;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic li);
    int n;
    n = 0;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_li = li;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: actual=in_ready_low required=accept_within_50");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    send(v.op, v.rd, v.rs1, v.rs2, v.f3, v.f7, v.imm, v.li);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #2;
    check32("rst_out_valid", 32'(out_valid), 32'h0);
    check32("rst_out_instruction", out_instruction, 32'h0);
    check32("rst_out_error", 32'(out_error), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    #1 check32("rst_in_ready", 32'(in_ready), 32'h1);

    // ADDI x1, x0, -1
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    check32("addi_valid", 32'(out_valid), 32'h1);
    check32("addi_word", out_instruction, 32'hFFF0_0093);
    check32("addi_err", 32'(out_error), 32'h0);

    // li x5, 0x12345FFF
    send(OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 1'b1);
    check32("li_lui_word", out_instruction, 32'h1234_62B7);
    check32("li_in_ready_second", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check32("li_addi_valid", 32'(out_valid), 32'h1);
    check32("li_addi_word", out_instruction, 32'hFFF2_8293);

    // BEQ x1, x2, -4 and misaligned offset
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
    check32("beq_word", out_instruction, 32'hFE20_8EE3);
    check32("beq_err", 32'(out_error), 32'h0);
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 1'b0);
    check32("beq_odd_err", 32'(out_error), 32'h1);

    // JAL x1, 8 and out of range
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0008, 1'b0);
    check32("jal_word", out_instruction, 32'h0080_00EF);
    check32("jal_err", 32'(out_error), 32'h0);
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 1'b0);
    check32("jal_range_err", 32'(out_error), 32'h1);

    // Unknown opcode emits NOP with error
    send(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'h0, 1'b0);
    check32("unk_word", out_instruction, 32'h0000_0013);
    check32("unk_err", 32'(out_error), 32'h1);

    // Directed table, first with no backpressure then with random backpressure
    vq.push_back('{OP_R,      5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b0});
    vq.push_back('{OP_LOAD,   5'd4, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFF8, 1'b0});
    vq.push_back('{OP_JALR,   5'd1, 5'd6, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 1'b0});
    vq.push_back('{OP_IMM,    5'd1, 5'd6, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 1'b0});
    vq.push_back('{OP_STORE,  5'd0, 5'd2, 5'd9, 3'd2, 7'h00, 32'hFFFF_F800, 1'b0});
    vq.push_back('{OP_STORE,  5'd0, 5'd2, 5'd9, 3'd2, 7'h00, 32'h0000_0800, 1'b0});
    vq.push_back('{OP_LUI,    5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCD_E000, 1'b0});
    vq.push_back('{OP_LUI,    5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0123, 1'b0});
    vq.push_back('{OP_AUIPC,  5'd8, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 1'b0});
    vq.push_back('{OP_BRANCH, 5'd0, 5'd3, 5'd4, 3'd1, 7'h00, 32'h0000_0FFE, 1'b0});
    vq.push_back('{OP_BRANCH, 5'd0, 5'd3, 5'd4, 3'd1, 7'h00, 32'h0000_1000, 1'b0});
    vq.push_back('{OP_JAL,    5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 1'b0});
    vq.push_back('{OP_JAL,    5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 1'b0});
    vq.push_back('{OP_IMM,    5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 1'b1});
    vq.push_back('{OP_IMM,    5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 1'b1});
    vq.push_back('{OP_IMM,    5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 1'b1});
    vq.push_back('{OP_IMM,    5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'h7FFF_F800, 1'b1});
    vq.push_back('{OP_IMM,    5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0000, 1'b1});
    vq.push_back('{OP_IMM,    5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'hDEAD_BEEF, 1'b1});
    foreach (vq[i]) send_vec(vq[i]);
    bp_en = 1'b1;
    foreach (vq[i]) send_vec(vq[i]);
    bp_en = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: word held, in_ready low, queued bundle not lost
    out_ready = 1'b0;
    send(OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0005, 1'b0);
    in_valid = 1'b1; in_opcode = OP_IMM; in_rd = 5'd8; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'h0000_0006; in_li = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check32("bp_word", out_instruction, 32'h0050_0393);
      check32("bp_valid", 32'(out_valid), 32'h1);
      check32("bp_in_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    check32("bp_next_word", out_instruction, 32'h0060_0413);
    repeat (2) @(posedge clk);
    #1;

    // Reset while the ADDI half of a li is pending
    send(OP_IMM, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 1'b1);
    check32("rst_li_lui", out_instruction, 32'h1234_6337);
    #1 reset_n = 1'b0;
    #1;
    check32("rst_mid_valid", 32'(out_valid), 32'h0);
    check32("rst_mid_word", out_instruction, 32'h0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check32("post_rst_no_addi", 32'(out_valid), 32'h0);
    end
    check32("model_queue_empty", 32'(expq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
